// File: rtl/encoder_rd_scheduler.sv
// Shares one I2C encoder-read master across four wheel channels. Arbitration is round-robin, and
// channels with a fresh angle_update win. A channel is flagged as faulted after repeated timeouts.
module encoder_rd_scheduler #(
  parameter int TIMEOUT_CYC = 2000,
  parameter int RD_GAP      = 16,
  parameter int FAIL_LIMIT  = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [3:0]  ch_enable,
  input  logic [3:0]  angle_update,
  input  logic        i2c_rd_valid,
  input  logic [11:0] i2c_rd_data,
  output logic        i2c_rd_start,
  output logic [1:0]  i2c_ch,
  output logic        i2c_abort,
  output logic [47:0] current_angle,
  output logic [3:0]  i2c_rd_done,
  output logic [3:0]  rd_fault
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int GW = $clog2(RD_GAP + 1);
  localparam int FW = $clog2(FAIL_LIMIT + 1);

  typedef enum logic [2:0] {IDLE, START, WAIT, DONE, GAP} state_t;

  state_t          state, state_nxt;
  logic [TW-1:0]   timer;
  logic [GW-1:0]   gap_cnt;
  logic [1:0]      last;
  logic [3:0]      pending;
  logic [FW-1:0]   fail_cnt [4];
  logic            en_lost;
  logic [3:0]      req_cls;
  logic [3:0]      clr_mask;
  logic [1:0]      pick;
  logic            pick_vld;
  logic            rd_ok;
  logic            rd_to;

  // Lowest priority goes to the channel just served (k == 4 wraps back onto 'from').
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] from);
    logic [2:0] r;
    logic [1:0] c;
    r = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      c = from + 2'(k);
      if (req[c]) r = {1'b1, c};
    end
    return r;
  endfunction

  function automatic logic [FW-1:0] sat_inc(input logic [FW-1:0] v);
    return (v == FW'(FAIL_LIMIT)) ? v : v + 1'b1;
  endfunction

  always_comb begin
    req_cls  = ((ch_enable & pending) != 4'b0000) ? (ch_enable & pending) : ch_enable;
    {pick_vld, pick} = rr_pick(req_cls, last);
    rd_ok    = (state == WAIT) && i2c_rd_valid;
    rd_to    = (state == WAIT) && !i2c_rd_valid && (timer == TW'(TIMEOUT_CYC - 1));
    clr_mask = (rd_ok || rd_to) ? (4'b0001 << i2c_ch) : 4'b0000;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld) state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT:    if (rd_ok) state_nxt = DONE;
               else if (rd_to) state_nxt = GAP;
      DONE:    state_nxt = GAP;
      GAP:     if (gap_cnt == GW'(RD_GAP - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      i2c_rd_start  <= 1'b0;
      i2c_abort     <= 1'b0;
      i2c_rd_done   <= 4'b0000;
      i2c_ch        <= 2'd0;
      last          <= 2'd3;
      pending       <= 4'b0000;
      rd_fault      <= 4'b0000;
      current_angle <= '0;
      timer         <= '0;
      gap_cnt       <= '0;
      en_lost       <= 1'b0;
      for (int n = 0; n < 4; n++) fail_cnt[n] <= '0;
    end else begin
      state        <= state_nxt;
      i2c_rd_start <= (state == IDLE) && pick_vld;
      i2c_abort    <= rd_to;
      i2c_rd_done  <= 4'b0000;
      // An update landing on the completion edge survives so the newer angle is still fetched.
      pending      <= (pending & ~clr_mask) | angle_update;

      if (state == DONE && ch_enable[i2c_ch] && !en_lost) i2c_rd_done[i2c_ch] <= 1'b1;

      if (state == IDLE && pick_vld) begin
        i2c_ch  <= pick;
        en_lost <= 1'b0;
      end else if ((state == START || state == WAIT || state == DONE) && !ch_enable[i2c_ch]) begin
        en_lost <= 1'b1;
      end

      if (state == START) timer <= '0;
      else if (state == WAIT) timer <= timer + 1'b1;

      if (state == GAP) gap_cnt <= gap_cnt + 1'b1;
      else gap_cnt <= '0;

      if (rd_ok) begin
        current_angle[12*i2c_ch +: 12] <= i2c_rd_data;
        fail_cnt[i2c_ch] <= '0;
        rd_fault[i2c_ch] <= 1'b0;
        last             <= i2c_ch;
      end else if (rd_to) begin
        fail_cnt[i2c_ch] <= sat_inc(fail_cnt[i2c_ch]);
        if (sat_inc(fail_cnt[i2c_ch]) == FW'(FAIL_LIMIT)) rd_fault[i2c_ch] <= 1'b1;
        last             <= i2c_ch;
      end
    end
  end

endmodule

// File: doc/encoder_rd_scheduler.md
# encoder_rd_scheduler

Time-shares the single I2C encoder-read master across the four swerve-wheel `pid` instances. It round-robins angle reads over the enabled wheels and gives priority to a wheel that has just received a new `angle_update`. Each read result is delivered to the owning `pid` as a held `current_angle` value plus a one-cycle `i2c_rd_done` strobe. A wheel whose reads keep timing out is flagged as faulted.

## Interface
- `TIMEOUT_CYC`, default 2000: cycles spent in WAIT with no `i2c_rd_valid` before the read is abandoned.
- `RD_GAP`, default 16: idle cycles inserted after every read (success or timeout) before the next arbitration.
- `FAIL_LIMIT`, default 3: number of consecutive timeouts on one channel that sets its fault flag.
- `clock` in 1: main clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `ch_enable` in 4: per-wheel read enable; tie to each wheel's `pwm_enable`.
- `angle_update` in 4: per-wheel pulse, the same one that drives that `pid`'s `angle_update`.
- `i2c_rd_valid` in 1: one-cycle pulse from the I2C master; read data is valid.
- `i2c_rd_data` in 12: encoder angle; sampled only when `i2c_rd_valid` is high.
- `i2c_rd_start` out 1: one-cycle read request to the I2C master.
- `i2c_ch` out 2: encoder select; held stable from START through the end of WAIT.
- `i2c_abort` out 1: one-cycle pulse issued on timeout.
- `current_angle` out 48: four 12-bit angles; channel n occupies bits [12n+11:12n].
- `i2c_rd_done` out 4: one-cycle strobe to `pid[n]` when its angle has been refreshed.
- `rd_fault` out 4: sticky per-channel fault flag.

## Operation
- States: IDLE, START, WAIT, DONE, GAP.
- IDLE:
  - Eligible channels are those with `ch_enable` set.
  - Pending eligible channels win over non-pending ones.
  - Within the winning class, round-robin starting at `last+1` (mod 4).
  - Latch the winner into `i2c_ch` and go to START.
  - If no channel is eligible, stay in IDLE.
- START: assert `i2c_rd_start` for one cycle, clear the timer, go to WAIT.
- WAIT, on `i2c_rd_valid`:
  - Write `i2c_rd_data` into `current_angle[i2c_ch]` on that edge.
  - Clear the channel's fail count and fault flag; set `last = i2c_ch`.
  - Go to DONE.
- WAIT, timeout: when the timer reaches `TIMEOUT_CYC-1` with no valid, pulse `i2c_abort` and go to GAP. The angle is held.
  - Increment the channel's fail count, saturating at `FAIL_LIMIT`.
  - Set `rd_fault[ch]` when the count reaches `FAIL_LIMIT`.
  - Set `last = ch`.
- DONE: pulse `i2c_rd_done[ch]` for one cycle, then go to GAP.
  - If `ch_enable[ch]` fell during the read, the angle is still written but the strobe is suppressed.
- GAP: count `RD_GAP` cycles, then return to IDLE.
- Pending flag:
  - Set by `angle_update[n]`.
  - Cleared when a read of channel n completes, by either success or timeout.
  - If set and clear occur in the same cycle, set wins, forcing a fresh read after the update.
- `i2c_rd_valid` outside WAIT is ignored, with no state or data change.
- Faulted channels remain eligible. A successful read clears the fault.

## Timing
- Reset values:
  - All outputs are 0: `current_angle`, `i2c_rd_done`, `rd_fault`, `i2c_rd_start`, `i2c_abort`, `i2c_ch`.
  - State is IDLE, pending flags are 0, fail counts are 0.
  - `last` resets to 3, so channel 0 is served first.
- Arbitration to request: eligible channel at edge k enters START at k+1, and `i2c_rd_start` is high during cycle k+1.
- Valid to strobe: `i2c_rd_valid` at edge v writes the angle at v, and `i2c_rd_done` is high for the cycle v+1 to v+2. The angle is therefore stable one full cycle before the strobe.
- Timeout: `i2c_abort` pulses exactly `TIMEOUT_CYC` cycles after entering WAIT.
- Minimum read period per slot: 1 (IDLE) + 1 (START) + wait + 1 (DONE) + `RD_GAP`.
- Reset mid-read: every register clears asynchronously, and no strobe or abort is issued. The I2C master must reset on the same `reset_n`.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- All four channels enabled, master answers 10 cycles after each start with 100/200/300/400:
  - Service order is 0,1,2,3,0.
  - Each `i2c_rd_done[n]` pulses once per pass, with the matching angle stable the cycle before.
- Round-robin at channel 1, `angle_update[3]` pulsed during the channel-1 read:
  - Next service is channel 3, not 2.
  - Then 0, 1, 2 follow in order.
- Master never asserts valid on channel 2:
  - `i2c_abort` pulses 2000 cycles after entering WAIT; angle 2 is unchanged and no strobe is issued.
  - After 3 passes `rd_fault[2]` = 1.
  - A following successful read clears `rd_fault[2]`.
- `ch_enable` = 4'b0101:
  - Only channels 0 and 2 are requested.
  - Dropping `ch_enable[2]` during its WAIT: angle is written, strobe is suppressed.
- Stray `i2c_rd_valid` in GAP/IDLE is ignored. `reset_n` low during WAIT clears all outputs, and after release the first request goes to channel 0.
